snake_game_ctrl: RTL and testbench

Top-level game-flow controller for the snake game. It sits downstream of the snake movement stage and consumes its hit_wall, hit_body and add_cube signals. It produces the game_status and die_flash that drive that stage and the renderer, and keeps a 2-digit BCD score and best score for display.

---
 rtl/snake_game_ctrl.sv | 170 +++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// Game-flow controller for the snake game: RESTART/START/PLAY/DIE sequencing,
// death flash timing, and BCD score / best-score keeping.
module snake_game_ctrl #(
    parameter int unsigned FLASH_HALF     = 12_500_000,
    parameter int unsigned FLASH_TOGGLES  = 8,
    parameter int unsigned RESTART_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_press,
    input  logic       hit_wall,
    input  logic       hit_body,
    input  logic       add_cube,
    output logic [1:0] game_status,
    output logic       die_flash,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic [3:0] best_tens,
    output logic [3:0] best_ones,
    output logic       new_record
);

    localparam int unsigned FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int unsigned TW = (FLASH_TOGGLES > 1) ? $clog2(FLASH_TOGGLES) : 1;
    localparam int unsigned RW = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RESTART = 2'b00,
        ST_START   = 2'b01,
        ST_PLAY    = 2'b10,
        ST_DIE     = 2'b11
    } state_t;

    state_t          r_state;
    logic            r_flash;
    logic [FW-1:0]   r_flash_cnt;
    logic [TW-1:0]   r_toggle_cnt;
    logic [RW-1:0]   r_restart_cnt;
    logic [3:0]      r_score_tens;
    logic [3:0]      r_score_ones;
    logic [3:0]      r_best_tens;
    logic [3:0]      r_best_ones;
    logic            r_new_record;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_start_prev;
    logic            r_start_edge;
    logic            r_add_prev;

    logic            w_add_edge;
    logic            w_hit;
    logic [3:0]      w_inc_tens;
    logic [3:0]      w_inc_ones;
    logic [3:0]      w_final_tens;
    logic [3:0]      w_final_ones;

    assign w_add_edge = add_cube & ~r_add_prev;
    assign w_hit      = hit_wall | hit_body;

    // Saturating BCD increment of the current score
    always_comb begin
        w_inc_tens = r_score_tens;
        w_inc_ones = r_score_ones;
        if (!(r_score_tens == 4'd9 && r_score_ones == 4'd9)) begin
            if (r_score_ones == 4'd9) begin
                w_inc_ones = 4'd0;
                w_inc_tens = r_score_tens + 4'd1;
            end else begin
                w_inc_ones = r_score_ones + 4'd1;
            end
        end
    end

    assign w_final_tens = w_add_edge ? w_inc_tens : r_score_tens;
    assign w_final_ones = w_add_edge ? w_inc_ones : r_score_ones;

    // start_press synchroniser with a registered rising-edge pulse; add_cube history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_start_prev <= 1'b0;
            r_start_edge <= 1'b0;
            r_add_prev   <= 1'b0;
        end else begin
            r_sync1      <= start_press;
            r_sync2      <= r_sync1;
            r_start_prev <= r_sync2;
            r_start_edge <= r_sync2 & ~r_start_prev;
            r_add_prev   <= add_cube;
        end
    end

    // Game FSM with score, best and flash bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_RESTART;
            r_flash       <= 1'b1;
            r_flash_cnt   <= '0;
            r_toggle_cnt  <= '0;
            r_restart_cnt <= '0;
            r_score_tens  <= 4'd0;
            r_score_ones  <= 4'd0;
            r_best_tens   <= 4'd0;
            r_best_ones   <= 4'd0;
            r_new_record  <= 1'b0;
        end else begin
            r_new_record <= 1'b0;
            case (r_state)
                ST_RESTART: begin
                    r_flash <= 1'b1;
                    if (r_restart_cnt == RW'(RESTART_CYCLES - 1)) begin
                        r_restart_cnt <= '0;
                        r_state       <= ST_START;
                    end else begin
                        r_restart_cnt <= r_restart_cnt + RW'(1);
                    end
                end
                ST_START: begin
                    if (r_start_edge) begin
                        r_state <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    r_score_tens <= w_final_tens;
                    r_score_ones <= w_final_ones;
                    if (w_hit) begin
                        r_state      <= ST_DIE;
                        r_flash      <= 1'b1;
                        r_flash_cnt  <= '0;
                        r_toggle_cnt <= '0;
                        // Final score already includes a same-cycle apple
                        if ({w_final_tens, w_final_ones} > {r_best_tens, r_best_ones}) begin
                            r_best_tens  <= w_final_tens;
                            r_best_ones  <= w_final_ones;
                            r_new_record <= 1'b1;
                        end
                    end
                end
                ST_DIE: begin
                    if (r_flash_cnt == FW'(FLASH_HALF - 1)) begin
                        r_flash_cnt <= '0;
                        if (r_toggle_cnt == TW'(FLASH_TOGGLES - 1)) begin
                            r_state       <= ST_RESTART;
                            r_flash       <= 1'b1;
                            r_toggle_cnt  <= '0;
                            r_restart_cnt <= '0;
                            r_score_tens  <= 4'd0;
                            r_score_ones  <= 4'd0;
                        end else begin
                            r_toggle_cnt <= r_toggle_cnt + TW'(1);
                            r_flash      <= ~r_flash;
                        end
                    end else begin
                        r_flash_cnt <= r_flash_cnt + FW'(1);
                    end
                end
            endcase
        end
    end

    assign game_status = r_state;
    assign die_flash   = r_flash;
    assign score_tens  = r_score_tens;
    assign score_ones  = r_score_ones;
    assign best_tens   = r_best_tens;
    assign best_ones   = r_best_ones;
    assign new_record  = r_new_record;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Randomised bench for snake_game_ctrl: a driver steps a decimal reference model and
// queues expected outputs; a negedge monitor pops and compares them.
module tb_snake_game_ctrl;

    localparam int FH = 4;
    localparam int FT = 8;
    localparam int RC = 2;

    logic       clk;
    logic       rst;
    logic       start_press;
    logic       hit_wall;
    logic       hit_body;
    logic       add_cube;
    logic [1:0] game_status;
    logic       die_flash;
    logic [3:0] score_tens;
    logic [3:0] score_ones;
    logic [3:0] best_tens;
    logic [3:0] best_ones;
    logic       new_record;

    snake_game_ctrl #(
        .FLASH_HALF    (FH),
        .FLASH_TOGGLES (FT),
        .RESTART_CYCLES(RC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_press(start_press),
        .hit_wall   (hit_wall),
        .hit_body   (hit_body),
        .add_cube   (add_cube),
        .game_status(game_status),
        .die_flash  (die_flash),
        .score_tens (score_tens),
        .score_ones (score_ones),
        .best_tens  (best_tens),
        .best_ones  (best_ones),
        .new_record (new_record)
    );

    typedef struct {
        int st;
        int flash;
        int sc;
        int best;
        int nr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 0;

    // Reference model, kept in plain decimal terms
    int m_st, m_score, m_best, m_n, m_nr;
    bit m_add_prev;
    bit sp_q[$];

    // Driven input levels
    bit d_rst, d_sp, d_hw, d_hb, d_add;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int m_flash();
        if (m_st == 3) return ((m_n / FH) % 2 == 0) ? 1 : 0;
        return 1;
    endfunction

    function automatic void model_reset();
        m_st = 0; m_score = 0; m_best = 0; m_n = 0; m_nr = 0; m_add_prev = 0;
        sp_q = '{0, 0, 0, 0, 0};
    endfunction

    // One clock edge of the game rules, using the inputs present at that edge
    function automatic void model_step();
        bit se, ae;
        sp_q.push_back(start_press);
        void'(sp_q.pop_front());
        se = sp_q[1] & ~sp_q[0];
        ae = add_cube & ~m_add_prev;
        m_add_prev = add_cube;
        m_nr = 0;
        case (m_st)
            0: begin
                m_n++;
                if (m_n == RC) begin m_st = 1; m_n = 0; end
            end
            1: if (se) m_st = 2;
            2: begin
                if (ae && m_score < 99) m_score++;
                if (hit_wall || hit_body) begin
                    m_st = 3; m_n = 0;
                    if (m_score > m_best) begin m_best = m_score; m_nr = 1; end
                end
            end
            default: begin
                m_n++;
                if (m_n == FH * FT) begin m_st = 0; m_n = 0; m_score = 0; end
            end
        endcase
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.st = m_st; e.flash = m_flash(); e.sc = m_score; e.best = m_best; e.nr = m_nr;
        exp_q.push_back(e);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        if (!rst) model_reset();
        else model_step();
        rst = d_rst; start_press = d_sp; hit_wall = d_hw; hit_body = d_hb; add_cube = d_add;
        if (!d_rst) model_reset();
        push_exp();
    endtask

    task automatic wait_st(int s, int lim);
        int k;
        k = 0;
        while (m_st != s && k < lim) begin cyc(); k++; end
        total++;
        if (m_st != s) begin
            bad++;
            $display("FAIL wait_state: model state %0d, required %0d within %0d cycles", m_st, s, lim);
        end
    endtask

    task automatic game(int n, bit long_first, bit combo, bit kill);
        wait_st(1, 200);
        d_sp = 1; repeat ($urandom_range(1, 5)) cyc(); d_sp = 0;
        wait_st(2, 20);
        d_sp = 1; repeat (3) cyc(); d_sp = 0; repeat (4) cyc();
        for (int i = 0; i < n; i++) begin
            d_add = 1;
            if (long_first && i == 0) repeat (100) cyc();
            else repeat ($urandom_range(1, 4)) cyc();
            d_add = 0;
            repeat ($urandom_range(1, 3)) cyc();
        end
        if ($urandom_range(0, 1) == 1) d_hw = 1; else d_hb = 1;
        if (combo) d_add = 1;
        cyc();
        d_add = 0;
        if (kill) begin
            for (int k = 0; k < 50 && !(m_st == 3 && m_flash() == 0); k++) cyc();
            d_rst = 0; cyc(); cyc();
            d_hw = 0; d_hb = 0; d_rst = 1;
            repeat (8) cyc();
            return;
        end
        for (int k = 0; k < 16; k++) begin
            d_sp = 1'($urandom_range(0, 1)); d_add = 1'($urandom_range(0, 1)); cyc();
        end
        d_sp = 0; d_add = 0;
        wait_st(0, 60);
        d_hw = 0; d_hb = 0;
        cyc();
    endtask

    task automatic chk(string nm, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: one expectation per cycle, compared on the falling edge
    initial begin
        exp_t e;
        #2;
        forever begin
            @(negedge clk);
            if (done) break;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard: got empty queue required one entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("game_status", int'(game_status), e.st);
                chk("die_flash", int'(die_flash), e.flash);
                chk("score", int'(score_tens) * 10 + int'(score_ones), e.sc);
                chk("score_ones_bcd", int'(score_ones), e.sc % 10);
                chk("best", int'(best_tens) * 10 + int'(best_ones), e.best);
                chk("best_ones_bcd", int'(best_ones), e.best % 10);
                chk("new_record", int'(new_record), e.nr);
            end
        end
    end

    initial begin
        rst = 0; start_press = 0; hit_wall = 0; hit_body = 0; add_cube = 0;
        d_rst = 0; d_sp = 0; d_hw = 0; d_hb = 0; d_add = 0;
        model_reset();
        repeat (2) cyc();
        d_rst = 1;
        repeat (12) cyc();
        game(5, 0, 0, 0);
        game(5, 0, 0, 0);
        game(7, 0, 0, 0);
        game(7, 0, 1, 0);
        game(12, 1, 0, 0);
        game(101, 0, 0, 0);
        for (int g = 0; g < 4; g++) game($urandom_range(0, 15), 0, 1'($urandom_range(0, 1)), 0);
        game(3, 0, 0, 1);
        game(2, 0, 1, 0);
        @(negedge clk);
        #1;
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
